lcd_bus_responder: RTL and testbench

Bus-side responder for the HD44780-compatible LCD 1602A interface, sitting at the pin end of the LCD controller path. It samples E/RS/RW/DB, assembles 4-bit nibble pairs into bytes, and decodes instructions and data writes. It tracks the address counter and busy flag, and answers busy-flag/address reads. The block is used as the display-side model in controller benches and in FPGA loopback builds.

---
 rtl/lcd_pkg.sv | 58 +++++
 rtl/lcd_busy_timer.sv | 29 ++
 rtl/lcd_bus_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared opcodes, address-counter wrap points, FSM encodings and decode helpers for the
// LCD bus responder.
package lcd_pkg;

    localparam logic [7:0] OpClear = 8'h01;
    localparam logic [7:0] OpHome  = 8'h02;
    localparam logic [7:0] OpEntry = 8'h04;
    localparam logic [7:0] OpDisp  = 8'h08;
    localparam logic [7:0] OpShift = 8'h10;
    localparam logic [7:0] OpFunc  = 8'h20;
    localparam logic [7:0] OpCgram = 8'h40;
    localparam logic [7:0] OpDdram = 8'h80;

    localparam logic [6:0] AcLine1End   = 7'h27;
    localparam logic [6:0] AcLine2Start = 7'h40;
    localparam logic [6:0] AcOneLineEnd = 7'h4F;
    localparam logic [6:0] AcLine2End   = 7'h67;

    localparam logic [7:0] RdDataByte = 8'h20;

    typedef enum logic [1:0] {StBoot8, StHi, StLo} if_state_e;

    typedef enum logic [3:0] {
        InstrNone, InstrClear, InstrHome, InstrEntry, InstrDisp,
        InstrShift, InstrFunc, InstrCgram, InstrDdram
    } instr_e;

    // Highest set bit selects the instruction.
    function automatic instr_e decode_instr(logic [7:0] b);
        if (b >= OpDdram)      return InstrDdram;
        else if (b >= OpCgram) return InstrCgram;
        else if (b >= OpFunc)  return InstrFunc;
        else if (b >= OpShift) return InstrShift;
        else if (b >= OpDisp)  return InstrDisp;
        else if (b >= OpEntry) return InstrEntry;
        else if (b >= OpHome)  return InstrHome;
        else if (b == OpClear) return InstrClear;
        else                   return InstrNone;
    endfunction

    function automatic logic [6:0] ac_step(logic [6:0] ac, logic inc, logic two_line);
        if (two_line) begin
            if (inc) begin
                if (ac == AcLine1End)      return AcLine2Start;
                else if (ac == AcLine2End) return 7'h00;
                else                       return ac + 7'd1;
            end else begin
                if (ac == 7'h00)             return AcLine2End;
                else if (ac == AcLine2Start) return AcLine1End;
                else                         return ac - 7'd1;
            end
        end else begin
            if (inc) return (ac == AcOneLineEnd) ? 7'h00 : ac + 7'd1;
            else     return (ac == 7'h00) ? AcOneLineEnd : ac - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Down-counter for the LCD busy flag; a start reloads it, busy holds for exactly load cycles.
module lcd_busy_timer #(
    parameter int unsigned Width = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] load,
    input  logic             start,
    output logic             busy,
    output logic             last
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start)              cnt_d = load;
        else if (cnt_q != '0)   cnt_d = cnt_q - Width'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == Width'(1));

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: nibble pairing, instruction decode, AC and busy tracking.
// Define LCD_RESP_BUSY_EN to build the busy counter and flag writes made while busy.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned T_SHORT     = 2100,
    parameter int unsigned T_LONG      = 82000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_db_in,
    output logic [3:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       instr_valid,
    output logic       data_valid,
    output logic [7:0] rx_byte,
    output logic [6:0] rx_addr,
    output logic       four_bit,
    output logic       busy,
    output logic       proto_err
);

    localparam int unsigned CntW = $clog2(T_LONG + 1);

    logic [6:0] sync_q [SYNC_STAGES];
    logic       e_prev_q;
    logic       e_s, rs_s, rw_s;
    logic [3:0] db_s;
    logic       wr_stb, rd_stb, e_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_db_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_prev_q <= e_s;
        end
    end

    assign {e_s, rs_s, rw_s, db_s} = sync_q[SYNC_STAGES-1];
    assign e_fall = e_prev_q & ~e_s;
    assign wr_stb = e_fall & ~rw_s;
    assign rd_stb = ~e_prev_q & e_s & rw_s;

    logic            busy_start, busy_long, busy_raw, busy_block;
    logic [CntW-1:0] busy_load;

    assign busy_load = busy_long ? CntW'(T_LONG) : CntW'(T_SHORT);

`ifdef LCD_RESP_BUSY_EN
    logic busy_last;

    lcd_busy_timer #(
        .Width(CntW)
    ) u_busy_timer (
        .clk  (clk),
        .rst  (rst),
        .load (busy_load),
        .start(busy_start),
        .busy (busy_raw),
        .last (busy_last)
    );

    // A write landing on the final busy cycle is accepted: expiry wins the tie.
    assign busy_block = busy_raw & ~busy_last;
`else
    logic unused_busy;
    assign unused_busy = ^{busy_start, busy_load};
    assign busy_raw    = 1'b0;
    assign busy_block  = 1'b0;
`endif

    if_state_e  state_q, state_d;
    logic [6:0] ac_q, ac_d, rx_addr_q, rx_addr_d;
    logic       id_q, id_d, n_q, n_d, rw_hi_q, rw_hi_d, drop_q, drop_d;
    logic       rd_data_q, rd_data_d, db_oe_q, db_oe_d;
    logic       instr_valid_q, instr_valid_d, data_valid_q, data_valid_d;
    logic       four_bit_q, four_bit_d, proto_err_q, proto_err_d;
    logic [3:0] hi_q, hi_d, db_out_q, db_out_d;
    logic [7:0] rd_byte_q, rd_byte_d, rx_byte_q, rx_byte_d;
    logic [7:0] wbyte, rbyte;
    logic       accept;

    always_comb begin
        state_d       = state_q;
        ac_d          = ac_q;
        id_d          = id_q;
        n_d           = n_q;
        hi_d          = hi_q;
        rw_hi_d       = rw_hi_q;
        drop_d        = drop_q;
        rd_byte_d     = rd_byte_q;
        rd_data_d     = rd_data_q;
        db_out_d      = db_out_q;
        db_oe_d       = db_oe_q;
        instr_valid_d = 1'b0;
        data_valid_d  = 1'b0;
        rx_byte_d     = rx_byte_q;
        rx_addr_d     = rx_addr_q;
        four_bit_d    = four_bit_q;
        proto_err_d   = proto_err_q;
        busy_start    = 1'b0;
        busy_long     = 1'b0;
        accept        = 1'b0;
        wbyte         = {hi_q, db_s};
        rbyte         = rs_s ? RdDataByte : {busy_raw, ac_q};

        if (e_fall) db_oe_d = 1'b0;

        if (wr_stb) begin
            unique case (state_q)
                StBoot8: begin
                    wbyte = {db_s, 4'h0};
                    if (busy_block)         proto_err_d = 1'b1;
                    else if (rs_s)          accept = 1'b1;
                    else if (db_s == 4'h2)  accept = 1'b1;
                    else if (db_s == 4'h3)  busy_start = 1'b1;
                end
                StHi: begin
                    hi_d    = db_s;
                    rw_hi_d = 1'b0;
                    drop_d  = busy_block;
                    state_d = StLo;
                    if (busy_block) proto_err_d = 1'b1;
                end
                StLo: begin
                    state_d = StHi;
                    if (rw_hi_q || drop_q || busy_block) proto_err_d = 1'b1;
                    else                                 accept = 1'b1;
                end
                default: state_d = StBoot8;
            endcase
        end

        if (rd_stb) begin
            unique case (state_q)
                StBoot8: begin
                    db_out_d = rbyte[7:4];
                    db_oe_d  = 1'b1;
                    if (rs_s) ac_d = ac_step(ac_q, id_q, n_q);
                end
                StHi: begin
                    rd_byte_d = rbyte;
                    rd_data_d = rs_s;
                    rw_hi_d   = 1'b1;
                    db_out_d  = rbyte[7:4];
                    db_oe_d   = 1'b1;
                    state_d   = StLo;
                end
                StLo: begin
                    state_d = StHi;
                    if (!rw_hi_q) begin
                        proto_err_d = 1'b1;
                    end else begin
                        db_out_d = rd_byte_q[3:0];
                        db_oe_d  = 1'b1;
                        if (rd_data_q) ac_d = ac_step(ac_q, id_q, n_q);
                    end
                end
                default: state_d = StBoot8;
            endcase
        end

        if (accept) begin
            rx_byte_d  = wbyte;
            busy_start = 1'b1;
            if (rs_s) begin
                data_valid_d = 1'b1;
                rx_addr_d    = ac_q;
                ac_d         = ac_step(ac_q, id_q, n_q);
            end else begin
                instr_valid_d = 1'b1;
                unique case (decode_instr(wbyte))
                    InstrClear: begin
                        ac_d      = 7'h00;
                        id_d      = 1'b1;
                        busy_long = 1'b1;
                    end
                    InstrHome: begin
                        ac_d      = 7'h00;
                        busy_long = 1'b1;
                    end
                    InstrEntry: id_d = wbyte[1];
                    InstrShift: if (!wbyte[3]) ac_d = ac_step(ac_q, wbyte[2], n_q);
                    InstrFunc: begin
                        n_d        = wbyte[3];
                        state_d    = wbyte[4] ? StBoot8 : StHi;
                        four_bit_d = ~wbyte[4];
                    end
                    InstrDdram: ac_d = wbyte[6:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StBoot8;
            ac_q          <= 7'h00;
            id_q          <= 1'b1;
            n_q           <= 1'b0;
            hi_q          <= 4'h0;
            rw_hi_q       <= 1'b0;
            drop_q        <= 1'b0;
            rd_byte_q     <= 8'h00;
            rd_data_q     <= 1'b0;
            db_out_q      <= 4'h0;
            db_oe_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            rx_byte_q     <= 8'h00;
            rx_addr_q     <= 7'h00;
            four_bit_q    <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ac_q          <= ac_d;
            id_q          <= id_d;
            n_q           <= n_d;
            hi_q          <= hi_d;
            rw_hi_q       <= rw_hi_d;
            drop_q        <= drop_d;
            rd_byte_q     <= rd_byte_d;
            rd_data_q     <= rd_data_d;
            db_out_q      <= db_out_d;
            db_oe_q       <= db_oe_d;
            instr_valid_q <= instr_valid_d;
            data_valid_q  <= data_valid_d;
            rx_byte_q     <= rx_byte_d;
            rx_addr_q     <= rx_addr_d;
            four_bit_q    <= four_bit_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign lcd_db_out  = db_out_q;
    assign lcd_db_oe   = db_oe_q;
    assign instr_valid = instr_valid_q;
    assign data_valid  = data_valid_q;
    assign rx_byte     = rx_byte_q;
    assign rx_addr     = rx_addr_q;
    assign four_bit    = four_bit_q;
    assign busy        = busy_raw;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder: drives HD44780 bus cycles, checks accepts and reads.
module tb_lcd_bus_responder;

    localparam int unsigned TS = 20;
    localparam int unsigned TL = 60;
    localparam int unsigned SS = 2;
`ifdef LCD_RESP_BUSY_EN
    localparam bit BusyEn = 1'b1;
`else
    localparam bit BusyEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [3:0] lcd_db_in = 4'h0;
    logic [3:0] lcd_db_out;
    logic       lcd_db_oe, instr_valid, data_valid, four_bit, busy, proto_err;
    logic [7:0] rx_byte;
    logic [6:0] rx_addr;

    lcd_bus_responder #(
        .T_SHORT    (TS),
        .T_LONG     (TL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_db_in  (lcd_db_in),
        .lcd_db_out (lcd_db_out),
        .lcd_db_oe  (lcd_db_oe),
        .instr_valid(instr_valid),
        .data_valid (data_valid),
        .rx_byte    (rx_byte),
        .rx_addr    (rx_addr),
        .four_bit   (four_bit),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // {is_data, byte, addr}
    logic [15:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [15:0] wr_e;
    logic [3:0]  rd_e;
    logic        oe_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (instr_valid || data_valid) begin
                if (wr_q.size() == 0) begin
                    check_val("unexp_wr", {instr_valid, data_valid}, 0);
                end else begin
                    wr_e = wr_q.pop_front();
                    check_val("wr_kind", {instr_valid, data_valid}, {~wr_e[15], wr_e[15]});
                    check_val("wr_byte", rx_byte, wr_e[14:7]);
                    if (wr_e[15]) check_val("wr_addr", rx_addr, wr_e[6:0]);
                    check_val("wr_lat", cyc - fall_cyc, SS + 1);
                    check_val("busy_on_valid", busy, BusyEn);
                end
            end
            if (lcd_db_oe && !oe_prev) begin
                if (rd_q.size() == 0) begin
                    check_val("unexp_rd", lcd_db_oe, 0);
                end else begin
                    rd_e = rd_q.pop_front();
                    check_val("rd_nibble", lcd_db_out, rd_e);
                    check_val("rd_lat", cyc - rise_cyc, SS + 1);
                end
            end
        end
        oe_prev = lcd_db_oe;
    end

    task automatic bus_write(input bit rs, input logic [3:0] nib);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b0; lcd_db_in = nib;
        repeat (2) @(posedge clk);
        #1 lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        fall_cyc = cyc;
        repeat (6) @(posedge clk);
    endtask

    task automatic bus_read(input bit rs);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b1;
        repeat (2) @(posedge clk);
        #1 lcd_e = 1'b1;
        rise_cyc = cyc;
        repeat (6) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_val("oe_drop", lcd_db_oe, 0);
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b, input logic [6:0] addr,
                             input bit expect_acc);
        if (expect_acc) wr_q.push_back({rs, b, addr});
        bus_write(rs, b[7:4]);
        bus_write(rs, b[3:0]);
    endtask

    task automatic read_byte(input bit rs, input logic [7:0] exp);
        rd_q.push_back(exp[7:4]);
        rd_q.push_back(exp[3:0]);
        bus_read(rs);
        bus_read(rs);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outs", {four_bit, proto_err, busy, lcd_db_oe, lcd_db_out, rx_byte,
                               rx_addr, instr_valid, data_valid}, 0);
        rst = 1'b1;
        idle(3);

        // Power-up in 8-bit mode, then switch to 4-bit two-line.
        bus_write(1'b0, 4'h3); idle(TS);
        bus_write(1'b0, 4'h3); idle(TS);
        bus_write(1'b0, 4'h3); idle(TS);
        check_val("boot_no_4bit", four_bit, 0);
        wr_q.push_back({1'b0, 8'h20, 7'h00});
        bus_write(1'b0, 4'h2); idle(TS);
        check_val("four_bit_on", four_bit, 1);
        send_byte(1'b0, 8'h28, 7'h00, 1'b1); idle(TS);

        // Line-1 end wraps to line 2.
        send_byte(1'b0, 8'hA7, 7'h00, 1'b1); idle(TS);
        send_byte(1'b0, 8'h06, 7'h00, 1'b1); idle(TS);
        send_byte(1'b1, 8'h41, 7'h27, 1'b1); idle(TS);
        send_byte(1'b1, 8'h42, 7'h40, 1'b1); idle(TS);
        check_val("rx_byte_hold", rx_byte, 8'h42);
        read_byte(1'b0, 8'h41);

        // CLEAR, then status while still busy, then after expiry.
        send_byte(1'b0, 8'h01, 7'h00, 1'b1);
        read_byte(1'b0, {BusyEn, 7'h00});
        idle(TL);
        read_byte(1'b0, 8'h00);

        // Data written straight after an instruction lands while busy.
        send_byte(1'b0, 8'h0C, 7'h00, 1'b1);
        send_byte(1'b1, 8'h55, 7'h00, !BusyEn);
        idle(TS);
        send_byte(1'b1, 8'h33, BusyEn ? 7'h00 : 7'h01, 1'b1); idle(TS);
        check_val("proto_busy", proto_err, BusyEn);

        // RW flips between the nibbles of a pair.
        bus_write(1'b0, 4'h8);
        bus_read(1'b0);
        send_byte(1'b0, 8'h80, 7'h00, 1'b1); idle(TS);
        check_val("proto_rw", proto_err, 1);

        // Decrement wrap from 0x00, data read, shift wrap at line-2 end.
        send_byte(1'b0, 8'h04, 7'h00, 1'b1); idle(TS);
        send_byte(1'b1, 8'h58, 7'h00, 1'b1); idle(TS);
        read_byte(1'b0, 8'h67);
        read_byte(1'b1, 8'h20);
        read_byte(1'b0, 8'h66);
        send_byte(1'b0, 8'h14, 7'h00, 1'b1); idle(TS);
        read_byte(1'b0, 8'h67);
        send_byte(1'b0, 8'h14, 7'h00, 1'b1); idle(TS);
        read_byte(1'b0, 8'h00);

        // Reset between nibbles of a pair.
        bus_write(1'b0, 4'h8);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_val("midpair_rst", {four_bit, proto_err, busy, lcd_db_oe, lcd_db_out, rx_byte,
                                  rx_addr, instr_valid, data_valid}, 0);
        #5 rst = 1'b1;
        idle(3);
        wr_q.push_back({1'b0, 8'h20, 7'h00});
        bus_write(1'b0, 4'h2); idle(TS);
        check_val("rst_boot8", four_bit, 1);
        check_val("rst_proto", proto_err, 0);

        check_val("wr_sb_drain", wr_q.size(), 0);
        check_val("rd_sb_drain", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
